// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, fixed-latency imem requests and a
// two-entry {instr, pc} buffer toward decode. Define FETCH_PERF_EN to add perf counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic        inflight;
    logic        head;
    logic [1:0]  count;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        pop;
    logic [1:0]  occupancy;
    logic        unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid & instr_ready;
    assign instr       = fifo_instr[head];
    assign instr_pc    = fifo_pc[head];

    // Entries still owed to the buffer after this cycle; a new request must leave room for its response.
    assign occupancy  = count + {1'b0, inflight} - {1'b0, pop};
    assign imem_rd_en = !rst && (state == RUN) && !redirect_valid && (occupancy < 2'd2);
    assign imem_addr  = imem_rd_en ? pc : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'd0;
        end else if (redirect_valid) begin
            state    <= FLUSH;
            pc       <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            state    <= RUN;
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
        end
    end

    // A response lands in the slot behind any surviving entry; a redirect drops everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= 32'd0;
                fifo_pc[i]    <= 32'd0;
            end
        end else if (redirect_valid) begin
            count <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_instr[head ^ count[0]] <= imem_rdata;
                fifo_pc[head ^ count[0]]    <= inflight_pc;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= occupancy;
        end
    end

`ifdef FETCH_PERF_EN
    // Counters run across redirects; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (instr_valid && !instr_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios plus a randomized
// run scored against an address-stream model; perf counters checked when FETCH_PERF_EN is defined.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic        instr_ready;
    logic [31:0] redirect_pc;
    logic        imem_rd_en, imem_rd_en2;
    logic        instr_valid, instr_valid2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic [31:0] instr, instr2;
    logic [31:0] instr_pc, instr_pc2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_rd_en(imem_rd_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched2), .perf_stall(perf_stall2)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One-cycle memory: data for the address presented at an edge appears after that edge; idle cycles return noise.
    always @(posedge clk) begin
        imem_rdata  <= imem_rd_en  ? mem_word(imem_addr)  : $urandom;
        imem_rdata2 <= imem_rd_en2 ? mem_word(imem_addr2) : $urandom;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b expected 0", imem_rd_en); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
        checks++; if (instr_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr_pc: got %h expected 0", instr_pc); end
        checks++; if (imem_addr2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr_wrapdut: got %h expected 0", imem_addr2); end
        rst = 1'b0;
        #1;
        checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL first_issue_en: got %b expected 1", imem_rd_en); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL first_issue_addr: got %h expected 0", imem_addr); end
        checks++; if (imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL first_issue_addr_wrapdut: got %h expected fffffff8", imem_addr2); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL stream_addr[%0d]: got %h expected %h", k, imem_addr, 32'(4 * k)); end
            checks++; if (instr_valid !== (k >= 2)) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", k, instr_valid, (k >= 2)); end
            if (k >= 2) begin
                exp_pc = 32'(4 * (k - 2));
                checks++; if (instr_pc !== exp_pc) begin errors++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", k, instr_pc, exp_pc); end
                checks++; if (instr !== mem_word(exp_pc)) begin errors++; $display("[TB] FAIL stream_instr[%0d]: got %h expected %h", k, instr, mem_word(exp_pc)); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                exp_pc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
                checks++; if (instr_valid2 !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid[%0d]: got %b expected 1", k, instr_valid2); end
                checks++; if (instr_pc2 !== exp_pc) begin errors++; $display("[TB] FAIL wrap_pc[%0d]: got %h expected %h", k, instr_pc2, exp_pc); end
                checks++; if (instr2 !== mem_word(exp_pc)) begin errors++; $display("[TB] FAIL wrap_instr[%0d]: got %h expected %h", k, instr2, mem_word(exp_pc)); end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        repeat (2) @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0) begin errors++; $display("[TB] FAIL bp_first_valid: got valid=%b pc=%h expected valid=1 pc=0", instr_valid, instr_pc); end
        instr_ready = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_rd_en[%0d]: got %b expected 0", j, imem_rd_en); end
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0) begin errors++; $display("[TB] FAIL bp_hold_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=0", j, instr_valid, instr_pc); end
            checks++; if (instr !== mem_word(32'd0)) begin errors++; $display("[TB] FAIL bp_hold_instr[%0d]: got %h expected %h", j, instr, mem_word(32'd0)); end
        end
        instr_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * j)) begin errors++; $display("[TB] FAIL bp_release_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", j, instr_valid, instr_pc, 32'(4 * j)); end
            checks++; if (instr !== mem_word(32'(4 * j))) begin errors++; $display("[TB] FAIL bp_release_instr[%0d]: got %h expected %h", j, instr, mem_word(32'(4 * j))); end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        repeat (2) @(negedge clk);
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        #1;
        checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL redir_no_issue: got %b expected 0", imem_rd_en); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flushed: got %b expected 0", instr_valid); end
        redirect_valid = 1'b0; instr_ready = 1'b1;
        #1;
        checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush_cycle: got %b expected 0", imem_rd_en); end
        @(negedge clk);
        checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_target_issue: got en=%b addr=%h expected en=1 addr=100", imem_rd_en, imem_addr); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h104) begin errors++; $display("[TB] FAIL redir_second_issue: got valid=%b addr=%h expected valid=0 addr=104", instr_valid, imem_addr); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin errors++; $display("[TB] FAIL redir_first_pc: got valid=%b pc=%h expected valid=1 pc=100", instr_valid, instr_pc); end
        checks++; if (instr !== mem_word(32'h100)) begin errors++; $display("[TB] FAIL redir_first_instr: got %h expected %h", instr, mem_word(32'h100)); end
        @(negedge clk);
        checks++; if (instr_pc !== 32'h104) begin errors++; $display("[TB] FAIL redir_second_pc: got %h expected 104", instr_pc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        apply_reset();
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || imem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_after_first: got valid=%b en=%b expected 0 0", instr_valid, imem_rd_en); end
        redirect_pc = 32'h80;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flush_cycle: got %b expected 0", imem_rd_en); end
        for (int j = 7; j <= 14; j++) begin
            @(negedge clk);
            checks++; if ((imem_rd_en && imem_addr == 32'h40) || (instr_valid && instr_pc == 32'h40)) begin errors++; $display("[TB] FAIL b2b_stale_target[%0d]: got addr=%h pc=%h expected no 40", j, imem_addr, instr_pc); end
            if (j == 7) begin
                checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h80) begin errors++; $display("[TB] FAIL b2b_issue: got en=%b addr=%h expected en=1 addr=80", imem_rd_en, imem_addr); end
            end else if (j >= 9) begin
                exp_pc = 32'h80 + 32'(4 * (j - 9));
                checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin errors++; $display("[TB] FAIL b2b_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", j, instr_valid, instr_pc, exp_pc); end
            end
        end
    endtask

    task automatic test_midreset();
        apply_reset();
        repeat (2) @(negedge clk);
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || imem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async: got valid=%b en=%b expected 0 0", instr_valid, imem_rd_en); end
        checks++; if (instr !== 32'd0 || instr_pc !== 32'd0 || imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL midrst_outputs: got instr=%h pc=%h addr=%h expected 0 0 0", instr, instr_pc, imem_addr); end
        @(negedge clk);
        rst = 1'b0; instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== mem_word(32'd0)) begin errors++; $display("[TB] FAIL midrst_restart: got valid=%b pc=%h instr=%h expected 1 0 %h", instr_valid, instr_pc, instr, mem_word(32'd0)); end
    endtask

    // Model: delivered PCs and issued addresses each form a +4 stream restarting at every redirect target;
    // their distance is the number of fetches still owed to the decoder.
    task automatic test_random();
        logic [31:0] exp_pc, exp_fetch, tgt, held_pc, held_instr, owed;
        logic        rdy, redir, flush, stalled, exp_rd;
        apply_reset();
        exp_pc = 32'd0; exp_fetch = 32'd0; flush = 1'b0; stalled = 1'b0;
        held_pc = 32'd0; held_instr = 32'd0;
        for (int n = 0; n < 400; n++) begin
            rdy = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 11) == 0);
            tgt = $urandom;
            instr_ready = rdy; redirect_valid = redir; redirect_pc = tgt;
            #1;
            if (stalled) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== held_pc || instr !== held_instr) begin errors++; $display("[TB] FAIL rnd_hold[%0d]: got valid=%b pc=%h instr=%h expected 1 %h %h", n, instr_valid, instr_pc, instr, held_pc, held_instr); end
            end
            if (instr_valid && rdy) begin
                checks++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin errors++; $display("[TB] FAIL rnd_deliver[%0d]: got pc=%h instr=%h expected %h %h", n, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            owed = (exp_fetch - exp_pc) >> 2;
            exp_rd = !redir && !flush && (owed < 32'd2);
            checks++; if (imem_rd_en !== exp_rd) begin errors++; $display("[TB] FAIL rnd_rd_en[%0d]: got %b expected %b", n, imem_rd_en, exp_rd); end
            if (exp_rd) begin
                checks++; if (imem_addr !== exp_fetch) begin errors++; $display("[TB] FAIL rnd_addr[%0d]: got %h expected %h", n, imem_addr, exp_fetch); end
                exp_fetch = exp_fetch + 32'd4;
            end
            stalled = instr_valid && !rdy && !redir;
            held_pc = instr_pc; held_instr = instr;
            if (redir) begin
                exp_pc = {tgt[31:2], 2'b00};
                exp_fetch = exp_pc;
            end
            flush = redir;
            @(negedge clk);
        end
        redirect_valid = 1'b0; instr_ready = 1'b1;
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        int pops, stalls;
        apply_reset();
        checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("[TB] FAIL perf_reset: got %0d %0d expected 0 0", perf_fetched, perf_stall); end
        pops = 0; stalls = 0;
        for (int n = 0; n < 60 && pops < 10; n++) begin
            @(negedge clk);
            instr_ready = !(instr_valid && pops == 4 && stalls < 3);
            if (instr_valid && instr_ready) pops++;
            else if (instr_valid) stalls++;
        end
        @(negedge clk);
        checks++; if (perf_fetched !== 32'd10) begin errors++; $display("[TB] FAIL perf_fetched: got %0d expected 10", perf_fetched); end
        checks++; if (perf_stall !== 32'd3) begin errors++; $display("[TB] FAIL perf_stall: got %0d expected 3", perf_stall); end
        instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("[TB] FAIL perf_midrst: got %0d %0d expected 0 0", perf_fetched, perf_stall); end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        test_reset();
        test_stream();
        test_wrap();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_midreset();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
